// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 16-bit down-counting timer with a 16-word register
// window (CTRL, LOAD, COUNT, STATUS), one-cycle registered read data and a
// level interrupt. Defining MMIO_TIMER_PRESCALER_EN adds a PRESCALE register
// at offset 4 that divides the tick rate; without it the timer ticks every
// cycle while running.
module mmio_timer #(
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 12'hFF0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic                  mem_enable_i,
  input  logic                  mem_rd_en_i,
  input  logic                  mem_wr_en_i,
  input  logic [15:0]           mem_value_i,
  output logic [15:0]           mem_value_o,
  output logic                  hit_o,
  output logic                  irq_o
);

  typedef enum logic {STOP, RUN} state_t;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_LOAD   = 4'd1;
  localparam logic [3:0] OFF_COUNT  = 4'd2;
  localparam logic [3:0] OFF_STATUS = 4'd3;
`ifdef MMIO_TIMER_PRESCALER_EN
  localparam logic [3:0] OFF_PRESCALE = 4'd4;
`endif

  state_t      state_q, state_n;
  logic [2:0]  ctrl_q, ctrl_n;
  logic [15:0] load_q, load_n;
  logic [15:0] count_q, count_n;
  logic        expired_q, expired_n;
  logic [15:0] rd_data;
  logic [3:0]  offset;
  logic        sel, rd_hit, wr_hit;
  logic        tick, count_wr, expire;
`ifdef MMIO_TIMER_PRESCALER_EN
  logic [15:0] prescale_q, prescale_n;
  logic [15:0] pre_cnt_q, pre_cnt_n;
`endif

  assign sel      = mem_enable_i && (mem_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign offset   = mem_addr_i[3:0];
  assign rd_hit   = sel && mem_rd_en_i;
  assign wr_hit   = sel && mem_wr_en_i;
  assign count_wr = wr_hit && (offset == OFF_COUNT);
`ifdef MMIO_TIMER_PRESCALER_EN
  assign tick     = (state_q == RUN) && (pre_cnt_q >= prescale_q);
`else
  assign tick     = (state_q == RUN);
`endif
  // A COUNT write in the same cycle cancels the whole expiry event.
  assign expire   = tick && (count_q == 16'd0) && !count_wr;
  assign irq_o    = expired_q && ctrl_q[2];

  // Read mux of the current register values; undefined offsets read as zero.
  always_comb begin
    rd_data = 16'd0;
    case (offset)
      OFF_CTRL:     rd_data = {13'd0, ctrl_q};
      OFF_LOAD:     rd_data = load_q;
      OFF_COUNT:    rd_data = count_q;
      OFF_STATUS:   rd_data = {15'd0, expired_q};
`ifdef MMIO_TIMER_PRESCALER_EN
      OFF_PRESCALE: rd_data = prescale_q;
`endif
      default:      rd_data = 16'd0;
    endcase
  end

  // Timer datapath: tick effects first, then bus writes so software wins,
  // and finally the expiry set so it beats a same-cycle W1C.
  always_comb begin
    ctrl_n    = ctrl_q;
    load_n    = load_q;
    count_n   = count_q;
    expired_n = expired_q;
    if (tick && !count_wr) begin
      if (count_q != 16'd0)
        count_n = count_q - 16'd1;
      else if (ctrl_q[1])
        count_n = load_q;
      else
        ctrl_n[0] = 1'b0;
    end
    if (wr_hit) begin
      case (offset)
        OFF_CTRL:   ctrl_n  = mem_value_i[2:0];
        OFF_LOAD:   load_n  = mem_value_i;
        OFF_COUNT:  count_n = mem_value_i;
        OFF_STATUS: if (mem_value_i[0]) expired_n = 1'b0;
        default:    ;
      endcase
    end
    if (expire)
      expired_n = 1'b1;
  end

`ifdef MMIO_TIMER_PRESCALER_EN
  // Prescale divider: counts while running, restarts on EN rising or a PRESCALE write.
  always_comb begin
    prescale_n = prescale_q;
    pre_cnt_n  = 16'd0;
    if ((state_q == RUN) && !tick)
      pre_cnt_n = pre_cnt_q + 16'd1;
    if (wr_hit && (offset == OFF_PRESCALE)) begin
      prescale_n = mem_value_i;
      pre_cnt_n  = 16'd0;
    end
    if (ctrl_n[0] && !ctrl_q[0])
      pre_cnt_n = 16'd0;
  end

  // Prescaler registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescale_q <= 16'd0;
      pre_cnt_q  <= 16'd0;
    end else begin
      prescale_q <= prescale_n;
      pre_cnt_q  <= pre_cnt_n;
    end
  end
`endif

  // STOP/RUN follows the EN bit as it will be after this edge.
  always_comb begin
    state_n = state_q;
    case (state_q)
      STOP:    if (ctrl_n[0])  state_n = RUN;
      RUN:     if (!ctrl_n[0]) state_n = STOP;
      default: state_n = STOP;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= STOP;
    else       state_q <= state_n;
  end

  // Software-visible registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= 3'd0;
      load_q    <= 16'd0;
      count_q   <= 16'd0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_n;
      load_q    <= load_n;
      count_q   <= count_n;
      expired_q <= expired_n;
    end
  end

  // Registered read response, zero whenever the previous cycle had no read hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_value_o <= 16'd0;
      hit_o       <= 1'b0;
    end else begin
      mem_value_o <= rd_hit ? rd_data : 16'd0;
      hit_o       <= rd_hit;
    end
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the memory-bus word address width.
REQ-002 The block SHALL have parameter BASE_ADDR, default 12'hFF0, meaning the base of a 16-word register window; it is 16-word aligned.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, all logic on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port mem_addr_i, input, ADDR_WIDTH bits: the CPU word address.
REQ-006 The block SHALL have port mem_enable_i, input, 1 bit: bus access strobe.
REQ-007 The block SHALL have port mem_rd_en_i, input, 1 bit: read request, qualified by mem_enable_i.
REQ-008 The block SHALL have port mem_wr_en_i, input, 1 bit: write request, qualified by mem_enable_i.
REQ-009 The block SHALL have port mem_value_i, input, 16 bits: CPU write data.
REQ-010 The block SHALL have port mem_value_o, output, 16 bits: registered read data.
REQ-011 The block SHALL have port hit_o, output, 1 bit: registered flag that mem_value_o holds valid read data from this block; the system read mux uses it.
REQ-012 The block SHALL have port irq_o, output, 1 bit: timer interrupt request.

Function
REQ-013 The block SHALL decode a hit when mem_enable_i=1 and mem_addr_i[ADDR_WIDTH-1:4]=BASE_ADDR[ADDR_WIDTH-1:4], with offset = mem_addr_i[3:0].
REQ-014 The block SHALL implement these registers: offset 0 CTRL (bit0 EN, bit1 RELOAD, bit2 IRQ_EN); offset 1 LOAD (16 bits); offset 2 COUNT (16 bits); offset 3 STATUS (bit0 EXPIRED, write-1-to-clear); unused bits read 0.
REQ-015 The block SHALL have a read latency of exactly 1 cycle: a hit with mem_rd_en_i in cycle N drives the register value, as sampled in cycle N, on mem_value_o with hit_o=1 in cycle N+1.
REQ-016 In cycles with no read hit in the previous cycle, the block SHALL drive mem_value_o=0 and hit_o=0.
REQ-017 The block SHALL apply writes at the clock edge ending the hit cycle; if rd and wr are both asserted, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-018 Reads of undefined offsets inside the window SHALL return 0 with hit_o=1, and writes to them SHALL be ignored; accesses outside the window SHALL have no effect.
REQ-019 The block SHALL implement a state machine with states STOP and RUN: STOP goes to RUN on the edge where CTRL.EN becomes 1, and RUN goes to STOP when CTRL.EN becomes 0.
REQ-020 In RUN, on each tick, the block SHALL decrement COUNT if it is nonzero; if COUNT=0 it SHALL set EXPIRED, then reload COUNT from LOAD if RELOAD=1, or else clear CTRL.EN and enter STOP; the period is LOAD+1 ticks.
REQ-021 Writing LOAD SHALL NOT alter COUNT; writing COUNT in RUN SHALL override that cycle's decrement or reload, and SHALL suppress EXPIRED setting for that cycle.
REQ-022 If a STATUS W1C and an expiry occur in the same cycle, the set SHALL win.
REQ-023 A CTRL write in the same cycle as a one-shot expiry SHALL take precedence over the automatic EN clear.
REQ-024 COUNT arithmetic SHALL be unsigned 16-bit and SHALL never wrap below 0.
REQ-025 The block SHALL drive irq_o = EXPIRED AND IRQ_EN, with no additional latency beyond the registers.

Reset
REQ-026 On rst_i=1 at a rising edge, the block SHALL clear CTRL, LOAD, COUNT and STATUS to 0, set the state to STOP, and drive mem_value_o=0, hit_o=0 and irq_o=0.
REQ-027 A reset in the middle of RUN or in the middle of a read SHALL abort the operation with no read response in the following cycle.
REQ-028 The block SHALL ignore bus accesses in a reset cycle.

Configuration
REQ-029 With macro MMIO_TIMER_PRESCALER_EN defined, the block SHALL add a 16-bit PRESCALE register at offset 4 (reset 0); a tick SHALL occur every PRESCALE+1 cycles, and the prescale counter SHALL restart on EN 0->1 or on a PRESCALE write.
REQ-030 Without MMIO_TIMER_PRESCALER_EN, a tick SHALL occur every cycle in RUN, and offset 4 SHALL behave as an undefined offset.

Verification
REQ-031 Write LOAD=3, COUNT=3, CTRL=0x3 -> COUNT goes 3,2,1,0; EXPIRED=1 on the 4th tick and COUNT=3 again; the period is 4 cycles thereafter.
REQ-032 Write COUNT=2, CTRL=0x5 (one-shot, IRQ_EN) -> irq_o=1 after 3 ticks, CTRL reads 0x4, COUNT stays 0; writing STATUS=1 -> irq_o=0 next cycle.
REQ-033 Read offset 2 at addr 0xFF2 in cycle N -> mem_value_o = COUNT as of cycle N, with hit_o=1, in N+1 only; a read at 0xFE2 -> hit_o=0 and mem_value_o=0.
REQ-034 Write STATUS=1 in the same cycle as an expiry -> EXPIRED reads 1; write COUNT=0x00FF in an expiry cycle -> COUNT=0x00FF and EXPIRED unchanged.
REQ-035 Assert rst_i for one cycle while RUN with COUNT=0x1234 -> all registers read 0 and hit_o=0 the following cycle.
REQ-036 With the macro defined, PRESCALE=2 and COUNT=1 in RUN -> EXPIRED is set 6 cycles after EN; without the macro, reading offset 4 -> 0.
